// File: rtl/uart_mem_loader_pkg.sv
// Shared command/response codes and FSM state type for the UART memory loader.
package uart_mem_loader_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_GO    = 8'h47;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StLen,
    StWdata,
    StWrite,
    StRreq,
    StRwait,
    StRsend,
    StAck,
    StNak
  } state_e;

endpackage

// File: rtl/uart_mem_loader_timeout.sv
// Inter-byte timeout counter: counts enabled idle cycles, flags the last one.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 12_000_000,
  parameter int unsigned TIMER_WIDTH    = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_WIDTH-1:0] LastCount = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMER_WIDTH-1:0] count_q;

  assign expired = enable && (count_q == LastCount);

  // Count idle cycles; saturate at the last count so expiry stays asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_mem_loader.sv
// Byte-stream command decoder that drives the memory bus and answers over UART.
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 12_000_000,
  parameter int unsigned TIMER_WIDTH    = $clog2(TIMEOUT_CYCLES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        bus_owner,
  output logic        go,
  output logic [31:0] go_addr
);

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] len_q, len_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        go_q, go_d;
  logic [31:0] go_addr_q, go_addr_d;

  logic timer_en, timer_clear, timer_expired;

  // Timeout only runs while waiting for bytes of a command.
  assign timer_en    = (state_q == StAddr) || (state_q == StLen) || (state_q == StWdata);
  assign timer_clear = rx_valid || !timer_en;

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMER_WIDTH   (TIMER_WIDTH)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = data_q;
  assign bus_owner = owner_q;
  assign go        = go_q;
  assign go_addr   = go_addr_q;

  // State and datapath registers; reset aborts any command silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cmd_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      go_q      <= 1'b0;
      go_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      go_q      <= go_d;
      go_addr_q <= go_addr_d;
    end
  end

  // Next-state and output decode; an arriving byte takes priority over expiry.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    len_d     = len_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    go_d      = 1'b0;
    go_addr_d = go_addr_q;
    mem_valid = 1'b0;
    mem_write = 1'b0;
    mem_wmask = 4'h0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ || rx_data == CMD_GO) begin
            cmd_d   = rx_data;
            cnt_d   = 2'd0;
            owner_d = 1'b1;
            state_d = StAddr;
          end else begin
            state_d = StNak;
          end
        end
      end
      StAddr: begin
        if (rx_valid) begin
          addr_d = {rx_data, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (cmd_q == CMD_GO) begin
              go_d      = 1'b1;
              go_addr_d = {addr_d[31:2], 2'b00};
              state_d   = StAck;
            end else begin
              state_d = StLen;
            end
          end
        end else if (timer_expired) begin
          state_d = StNak;
        end
      end
      StLen: begin
        if (rx_valid) begin
          len_d = {rx_data, len_q[15:8]};
          if (cnt_q == 2'd1) begin
            cnt_d = 2'd0;
            if (len_d == 16'd0) begin
              state_d = StAck;
            end else if (cmd_q == CMD_WRITE) begin
              state_d = StWdata;
            end else begin
              state_d = StRreq;
            end
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (timer_expired) begin
          state_d = StNak;
        end
      end
      StWdata: begin
        if (rx_valid) begin
          data_d = {rx_data, data_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = StWrite;
          end
        end else if (timer_expired) begin
          state_d = StNak;
        end
      end
      StWrite: begin
        mem_valid = 1'b1;
        mem_write = 1'b1;
        mem_wmask = 4'hF;
        addr_d    = addr_q + 32'd4;
        len_d     = len_q - 16'd1;
        state_d   = (len_q == 16'd1) ? StAck : StWdata;
      end
      StRreq: begin
        mem_valid = 1'b1;
        state_d   = StRwait;
      end
      StRwait: begin
        data_d  = mem_rdata;
        cnt_d   = 2'd0;
        state_d = StRsend;
      end
      StRsend: begin
        tx_valid = 1'b1;
        tx_data  = data_q[{cnt_q, 3'b000} +: 8];
        if (tx_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            addr_d  = addr_q + 32'd4;
            len_d   = len_q - 16'd1;
            state_d = (len_q == 16'd1) ? StAck : StRreq;
          end
        end
      end
      StAck: begin
        tx_valid = 1'b1;
        tx_data  = RSP_ACK;
        if (tx_ready) begin
          owner_d = 1'b0;
          state_d = StIdle;
        end
      end
      StNak: begin
        tx_valid = 1'b1;
        tx_data  = RSP_NAK;
        if (tx_ready) begin
          owner_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Randomized scoreboard bench for uart_mem_loader with a word-level protocol model.
module tb_uart_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        mem_valid;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        bus_owner;
  logic        go;
  logic [31:0] go_addr;

  uart_mem_loader #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .mem_valid(mem_valid),
    .mem_write(mem_write),
    .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .bus_owner(bus_owner),
    .go       (go),
    .go_addr  (go_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_op_t;

  mem_op_t     mem_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] go_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wbuf[$];

  int          checks = 0;
  int          failures = 0;
  int          tx_mode = 0;
  int          lc = 0;
  int          rd_issue = 0;
  int          rd_served = 0;
  logic [31:0] rd_val = '0;
  logic        tx_hold = 1'b0;
  logic [7:0]  hold_byte = '0;
  logic [31:0] exp_go_addr = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL unexpected_%s actual=%0h expected=nothing", name, act);
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], 16'hC0DE} ^ 32'h3C00_0000;
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Scoreboard monitor: compares every bus cycle, tx handshake and go pulse.
  always @(negedge clk) begin
    if (rst) begin
      tx_hold = 1'b0;
    end else begin
      if (tx_hold && tx_valid) check("tx_stable", tx_data, hold_byte);
      tx_hold   = tx_valid && !tx_ready;
      hold_byte = tx_data;
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) unexpected("tx", {24'h0, tx_data});
        else check("tx_byte", tx_data, tx_q.pop_front());
      end
      if (mem_valid) begin
        if (mem_q.size() == 0) begin
          unexpected("mem", mem_addr);
        end else begin
          mem_op_t e;
          e = mem_q.pop_front();
          check("mem_write", mem_write, e.wr);
          check("mem_addr", mem_addr, e.addr);
          check("mem_wmask", mem_wmask, e.wr ? 4'hF : 4'h0);
          if (e.wr) begin
            check("mem_wdata", mem_wdata, e.data);
          end else begin
            rd_val = mem_read(e.addr);
            rd_issue++;
          end
        end
      end
      if (go) begin
        if (go_q.size() == 0) unexpected("go", go_addr);
        else check("go_addr", go_addr, go_q.pop_front());
      end
    end
  end

  // Memory responder: read data appears only in the cycle after the request.
  always @(posedge clk) begin
    #1;
    if (rd_served != rd_issue) begin
      mem_rdata = rd_val;
      rd_served = rd_issue;
    end else begin
      mem_rdata = $urandom;
    end
  end

  // Transmitter model: random readiness, or hold-off of 5 cycles per byte.
  always @(posedge clk) begin
    #1;
    if (tx_mode == 0) begin
      tx_ready = 1'($urandom_range(0, 1));
    end else if (!tx_valid) begin
      tx_ready = 1'b0;
      lc = 0;
    end else if (lc < 5) begin
      tx_ready = 1'b0;
      lc++;
    end else begin
      tx_ready = 1'b1;
      lc = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic flush();
    mem_q.delete();
    tx_q.delete();
    go_q.delete();
  endtask

  task automatic wait_done(input int budget, input bit chk_low);
    int n = 0;
    while ((mem_q.size() != 0 || tx_q.size() != 0 || go_q.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      if (chk_low) check("owner_low", bus_owner, 1'b0);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL response_timeout pending_tx=%0d pending_mem=%0d required=0",
               tx_q.size(), mem_q.size());
      flush();
    end
    @(posedge clk);
    #1;
    check("owner_released", bus_owner, 1'b0);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {tx_valid, tx_data, mem_valid, mem_write, mem_wmask, mem_wdata, mem_addr,
                 bus_owner, go, go_addr}, '0);
  endtask

  // Write command: words come from wbuf; each word lands at the next address.
  task automatic do_write(input logic [31:0] a);
    int len = wbuf.size();
    for (int i = 0; i < len; i++) begin
      logic [31:0] wa;
      wa = word_addr(a) + 32'(4 * i);
      mem_q.push_back('{1'b1, wa, wbuf[i]});
      mem[wa] = wbuf[i];
    end
    tx_q.push_back(8'h06);
    send_byte(8'h57);
    send_word(a);
    send_byte(8'(len));
    send_byte(8'(len >> 8));
    for (int i = 0; i < len; i++) send_word(wbuf[i]);
    wait_done(3000, 1'b0);
  endtask

  task automatic issue_read(input logic [31:0] a, input int len);
    for (int i = 0; i < len; i++) begin
      logic [31:0] ra;
      logic [31:0] d;
      ra = word_addr(a) + 32'(4 * i);
      d  = mem_read(ra);
      mem_q.push_back('{1'b0, ra, 32'h0});
      for (int k = 0; k < 4; k++) tx_q.push_back(d[8*k +: 8]);
    end
    tx_q.push_back(8'h06);
    send_byte(8'h52);
    send_word(a);
    send_byte(8'(len));
    send_byte(8'(len >> 8));
  endtask

  task automatic do_read(input logic [31:0] a, input int len);
    issue_read(a, len);
    wait_done(3000, 1'b0);
  endtask

  task automatic do_go(input logic [31:0] a);
    exp_go_addr = word_addr(a);
    go_q.push_back(exp_go_addr);
    tx_q.push_back(8'h06);
    send_byte(8'h47);
    send_word(a);
    wait_done(500, 1'b0);
    check("go_addr_held", go_addr, exp_go_addr);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] last_w;
    bit          have_w;
    int          n;
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    tx_ready  = 1'b0;
    mem_rdata = 32'h0;
    have_w    = 1'b0;
    last_w    = '0;
    #1;
    check_outputs_zero("reset_outputs");
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    wbuf = '{32'h4433_2211, 32'hDDCC_BBAA};
    do_write(32'h0000_0010);

    mem[32'h0002_0000] = 32'hDEAD_BEEF;
    tx_mode = 1;
    do_read(32'h0002_0000, 1);
    tx_mode = 0;

    do_go(32'h0000_0003);

    tx_q.push_back(8'h15);
    send_byte(8'h41);
    wait_done(200, 1'b1);

    wbuf.delete();
    do_write(32'h0000_0040);

    // Silence after two data bytes: nothing written, NAK returned.
    tx_q.push_back(8'h15);
    send_byte(8'h57);
    send_word(32'h0000_0100);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h5A);
    send_byte(8'hA5);
    wait_done(200, 1'b0);

    // First word completes before the stall and must stay written.
    mem_q.push_back('{1'b1, 32'h0000_0200, 32'h1234_5678});
    mem[32'h0000_0200] = 32'h1234_5678;
    tx_q.push_back(8'h15);
    send_byte(8'h57);
    send_word(32'h0000_0200);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h1234_5678);
    send_byte(8'h99);
    send_byte(8'h88);
    wait_done(200, 1'b0);
    do_read(32'h0000_0200, 1);

    wbuf = '{32'hCAFE_0001, 32'hCAFE_0002};
    do_write(32'hFFFF_FFFC);
    do_read(32'hFFFF_FFFC, 2);

    for (int it = 0; it < 30; it++) begin
      int op;
      int len;
      op  = $urandom_range(0, 2);
      len = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else a = $urandom;
      if (op == 1 && have_w && $urandom_range(0, 1) == 1) a = last_w;
      case (op)
        0: begin
          wbuf.delete();
          for (int i = 0; i < len; i++) wbuf.push_back($urandom);
          do_write(a);
          last_w = a;
          have_w = 1'b1;
        end
        1: do_read(a, len);
        default: do_go(a);
      endcase
    end

    // Abort in the middle of streaming read data.
    issue_read(32'h0000_0300, 2);
    n = 0;
    while (!tx_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reached_rsend", tx_valid, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("async_reset_outputs");
    flush();
    exp_go_addr = '0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;

    wbuf = '{32'h0BAD_F00D};
    do_write(32'h0000_0400);
    do_read(32'h0000_0400, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
